// File: rtl/ddiff_pwm_shaper.sv
// ddiff_pwm_shaper: shift-weighted delayed-difference correction on A, 16-bit saturation,
// and a period-latched PWM driven from the top PWM_BITS bits of the shaped sample.
module ddiff_pwm_shaper #(
  parameter int unsigned W1       = 0,
  parameter int unsigned W2       = 2,
  parameter int unsigned W3       = 4,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         A,
  input  logic [15:0]         dd1,
  input  logic                dd1s,
  input  logic [15:0]         dd2,
  input  logic                dd2s,
  input  logic [15:0]         dd3,
  input  logic                dd3s,
  output logic [15:0]         sample,
  output logic                sat_hi,
  output logic                sat_lo,
  output logic [PWM_BITS-1:0] duty,
  output logic                period_start,
  output logic                pwm_out
);
  logic [15:0]         a1_q;
  logic [16:0]         m1, m2, m3, t1_d, t2_d, t3_d, t1_q, t2_q, t3_q;
  logic [18:0]         s_d, s_q;
  logic [15:0]         sample_d, sample_q;
  logic                sat_hi_d, sat_lo_d, sat_hi_q, sat_lo_q;
  logic [PWM_BITS-1:0] cnt_q, duty_d, duty_q;
  logic                wrap, period_start_q;
  // shift the magnitude before negating so truncation is toward zero and -0 stays 0
  always_comb begin
    m1       = {1'b0, dd1 >> W1};
    m2       = {1'b0, dd2 >> W2};
    m3       = {1'b0, dd3 >> W3};
    t1_d     = dd1s ? -m1 : m1;
    t2_d     = dd2s ? -m2 : m2;
    t3_d     = dd3s ? -m3 : m3;
    s_d      = {3'b0, a1_q} + {{2{t1_q[16]}}, t1_q} + {{2{t2_q[16]}}, t2_q} + {{2{t3_q[16]}}, t3_q};
    sat_lo_d = s_q[18];
    sat_hi_d = ~s_q[18] & |s_q[17:16];
    sample_d = sat_lo_d ? 16'h0000 : sat_hi_d ? 16'hFFFF : s_q[15:0];
    wrap     = &cnt_q;
    duty_d   = wrap ? sample_q[15 -: PWM_BITS] : duty_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a1_q           <= '0;
      t1_q           <= '0;
      t2_q           <= '0;
      t3_q           <= '0;
      s_q            <= '0;
      sample_q       <= '0;
      sat_hi_q       <= 1'b0;
      sat_lo_q       <= 1'b0;
      cnt_q          <= '0;
      duty_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      a1_q           <= A;
      t1_q           <= t1_d;
      t2_q           <= t2_d;
      t3_q           <= t3_d;
      s_q            <= s_d;
      sample_q       <= sample_d;
      sat_hi_q       <= sat_hi_d;
      sat_lo_q       <= sat_lo_d;
      cnt_q          <= cnt_q + 1'b1;
      duty_q         <= duty_d;
      period_start_q <= wrap;
    end
  end
  assign sample       = sample_q;
  assign sat_hi       = sat_hi_q;
  assign sat_lo       = sat_lo_q;
  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign pwm_out      = cnt_q < duty_q;
endmodule

// File: tb/tb_ddiff_pwm_shaper.sv
// tb_ddiff_pwm_shaper: directed vectors; expectations queued with their due cycle, a monitor
// pops and compares them on the falling edge.
module tb_ddiff_pwm_shaper;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] A = '0, dd1 = '0, dd2 = '0, dd3 = '0;
  logic        dd1s = 1'b0, dd2s = 1'b0, dd3s = 1'b0;
  logic [15:0] sample;
  logic        sat_hi, sat_lo, period_start, pwm_out;
  logic [7:0]  duty;
  localparam int K_SMP = 0, K_DUTY = 1, K_PS = 2, K_PWM = 3, K_WIN = 4, K_HI = 5, K_PSN = 6;
  typedef struct {int cyc; int kind; int val; string name;} ent_t;
  ent_t q[$];
  int cyc = 0, rcyc = 0, tests = 0, fails = 0, hi_acc = 0, ps_acc = 0;

  ddiff_pwm_shaper dut (
    .clk(clk), .rst(rst), .A(A),
    .dd1(dd1), .dd1s(dd1s), .dd2(dd2), .dd2s(dd2s), .dd3(dd3), .dd3s(dd3s),
    .sample(sample), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .duty(duty), .period_start(period_start), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int act;
    foreach (q[i]) if (q[i].kind == K_WIN && q[i].cyc == cyc) begin
      hi_acc = 0;
      ps_acc = 0;
    end
    hi_acc += int'(pwm_out);
    ps_acc += int'(period_start);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].cyc == cyc) begin
      if (q[i].kind != K_WIN) begin
        act = q[i].kind == K_SMP  ? int'({sample, sat_hi, sat_lo}) :
              q[i].kind == K_DUTY ? int'(duty) :
              q[i].kind == K_PS   ? int'(period_start) :
              q[i].kind == K_PWM  ? int'(pwm_out) :
              q[i].kind == K_HI   ? hi_acc : ps_acc;
        tests++;
        if (act != q[i].val) begin
          fails++;
          $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", q[i].name, cyc, act, q[i].val);
        end
      end
      q.delete(i);
    end
  end

  task automatic exp_at(input int t, input int k, input int v, input string n);
    q.push_back('{rcyc + t, k, v, n});
  endtask

  task automatic smp(input int t, input logic [15:0] s, input logic hi, input logic lo, input string n);
    exp_at(t, K_SMP, int'({s, hi, lo}), n);
  endtask

  task automatic win(input int t0, input int hi, input int psn);
    exp_at(t0, K_WIN, 0, "window");
    exp_at(t0 + 255, K_HI, hi, "pwm_high_cycles");
    exp_at(t0 + 255, K_PSN, psn, "period_start_pulses");
  endtask

  task automatic at(input int t);
    while (cyc - rcyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d1, input logic s1,
                       input logic [15:0] d2, input logic s2, input logic [15:0] d3, input logic s3);
    A = a; dd1 = d1; dd1s = s1; dd2 = d2; dd2s = s2; dd3 = d3; dd3s = s3;
  endtask

  task automatic reset_checks();
    smp(0, 16'h0000, 1'b0, 1'b0, "reset_sample");
    exp_at(0, K_DUTY, 0, "reset_duty");
    exp_at(0, K_PS, 0, "reset_period_start");
    exp_at(0, K_PWM, 0, "reset_pwm");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    rcyc = cyc;
    reset_checks();
    // 0x8000 + 0x100 - (0x40>>2) + (0x10>>4) = 0x80F1
    drive(16'h8000, 16'h0100, 1'b0, 16'h0040, 1'b1, 16'h0010, 1'b0);
    smp(2, 16'h0000, 1'b0, 1'b0, "latency_not_early");
    smp(3, 16'h80F1, 1'b0, 1'b0, "weighted_sum");
    exp_at(1, K_PS, 0, "no_pulse_first_period");
    exp_at(255, K_DUTY, 0, "duty_before_wrap");
    exp_at(255, K_PS, 0, "ps_before_wrap");
    exp_at(256, K_DUTY, 8'h80, "duty_after_wrap");
    exp_at(256, K_PS, 1, "ps_at_wrap");
    win(256, 128, 1);
    at(260); drive(16'hFFF0, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    smp(263, 16'hFFFF, 1'b1, 1'b0, "sat_hi");
    at(261); drive(16'h0010, 16'h0100, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    smp(264, 16'h0000, 1'b0, 1'b1, "sat_lo");
    at(262); drive(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    smp(265, 16'hFFFF, 1'b0, 1'b0, "exact_ffff");
    at(263); drive(16'h1234, 16'h0000, 1'b0, 16'h0003, 1'b1, 16'h0000, 1'b0);
    smp(266, 16'h1234, 1'b0, 1'b0, "trunc_toward_zero");
    at(264); drive(16'h4321, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    smp(267, 16'h4321, 1'b0, 1'b0, "negative_zero");
    at(265); drive(16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    smp(268, 16'h1234, 1'b0, 1'b0, "passthrough");
    at(266); drive(16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    smp(269, 16'h0000, 1'b0, 1'b0, "exact_zero");
    at(267); drive(16'h1000, 16'h0001, 1'b0, 16'h0007, 1'b0, 16'h00FF, 1'b1);
    smp(270, 16'h0FF3, 1'b0, 1'b0, "mixed_weights");
    at(268); drive(16'h2000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    smp(271, 16'h2000, 1'b0, 1'b0, "duty_src_2000");
    exp_at(512, K_DUTY, 8'h20, "duty_20");
    win(512, 32, 1);
    at(612); A = 16'hC000;
    smp(615, 16'hC000, 1'b0, 1'b0, "duty_src_c000");
    exp_at(700, K_DUTY, 8'h20, "duty_held_mid");
    exp_at(767, K_DUTY, 8'h20, "duty_held_end");
    exp_at(768, K_DUTY, 8'hC0, "duty_c0");
    win(768, 192, 1);
    at(800); A = 16'h0000;
    exp_at(1024, K_DUTY, 0, "duty_zero");
    win(1024, 0, 1);
    at(1100); A = 16'hFFFF;
    exp_at(1280, K_DUTY, 8'hFF, "duty_ff");
    win(1280, 255, 1);
    exp_at(1534, K_PWM, 1, "pwm_cnt254");
    exp_at(1535, K_PWM, 0, "pwm_cnt255");
    at(1300); A = 16'h8000;
    exp_at(1536, K_DUTY, 8'h80, "duty_80_pre_reset");
    at(1613);
    exp_at(1613, K_PWM, 1, "pwm_cnt77");
    exp_at(1613, K_DUTY, 8'h80, "duty_cnt77");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rcyc = cyc;
    reset_checks();
    smp(2, 16'h0000, 1'b0, 1'b0, "post_rst_fill");
    smp(3, 16'h8000, 1'b0, 1'b0, "post_rst_sample");
    exp_at(255, K_DUTY, 0, "post_rst_duty_hold");
    exp_at(255, K_PS, 0, "post_rst_ps_before_wrap");
    exp_at(256, K_DUTY, 8'h80, "post_rst_duty");
    exp_at(256, K_PS, 1, "post_rst_ps_wrap");
    win(0, 0, 0);
    win(256, 128, 1);
    at(520);
    foreach (q[i]) if (q[i].kind != K_WIN) begin
      tests++;
      fails++;
      $display("FAIL %s: never checked (due cyc=%0d, now %0d)", q[i].name, q[i].cyc, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
